conv_bias_apply_stream: RTL and testbench
=========================================

Name: conv_bias_apply_stream

Overview:
- Streaming bias-add and requantise stage that sits between a conv layer's MAC accumulator output and the next layer's input buffer.
- It is the reader side of the per-layer bias ROM. It drives the ROM's row/col address from an internal output-channel counter and consumes the combinational signed Q1.7 `data` in the same cycle.
- Each accepted accumulator beat (Q.14) gets its channel's bias added, is rounded, saturated to Q1.7 and optionally passed through ReLU, then leaves on a valid/ready stream.

Parameters:
- NUM_CH, 16, output channels per pixel; sets ROM row range and channel-counter wrap.
- ACC_W, 24, signed accumulator width (Q(ACC_W-14).14).
- FRAC, 7, fractional bits of the bias/output format; the bias is aligned by <<FRAC.
- RELU_EN, 1, 1 = clamp negative results to 0 after saturation.

Ports:
- clk, in, 1, clock.
- rst, in, 1, synchronous active-high reset.
- ch_clr, in, 1, synchronous clear of the channel counter (start of a new layer/frame).
- s_valid, in, 1, accumulator beat valid.
- s_ready, out, 1, stage can accept a beat.
- s_data, in, ACC_W, signed accumulator Q.14.
- rom_row, out, 16, bias ROM row address (channel index, zero-extended).
- rom_col, out, 16, bias ROM column address; constant 0.
- rom_data, in, 8, signed Q1.7 bias returned combinationally by the ROM.
- m_valid, out, 1, result valid.
- m_ready, in, 1, downstream accepts the result.
- m_data, out, 8, signed Q1.7 result.
- m_ch, out, 16, channel index of m_data.
- m_last_ch, out, 1, high when m_ch == NUM_CH-1.

Behaviour:
- Reset (rst high at a clk edge) clears:
  - ch_cnt = 0
  - m_valid = 0
  - m_data = 0
  - m_ch = 0
  - m_last_ch = 0
- Reset mid-stream discards any held result and does not complete a pending handshake. s_ready is 1 on the first cycle after reset.
- Addressing:
  - rom_row = ch_clr ? 0 : ch_cnt.
  - rom_col = 0 always.
  - rom_data is sampled in the same cycle as the address is driven; the ROM has no read latency.
- Handshake and pipelining:
  - Single output register; latency 1 cycle from an accepted beat to m_valid.
  - s_ready = !m_valid || m_ready (combinational). accept = s_valid && s_ready.
  - accept loads the result register and sets m_valid = 1.
  - m_valid && m_ready && !accept clears m_valid.
  - Full throughput of 1 beat/cycle when m_ready is held high.
  - m_data, m_ch and m_last_ch hold stable while m_valid && !m_ready.
- Channel counter:
  - On accept, ch_cnt increments and wraps from NUM_CH-1 to 0.
  - ch_clr without accept: ch_cnt <= 0.
  - ch_clr with accept: the beat uses channel 0 and ch_cnt <= 1 (or 0 when NUM_CH == 1).
  - ch_clr has no effect on m_valid or the held result.
- Arithmetic, all signed, width ACC_W+2:
  - sum = s_data + (sext(rom_data) << FRAC)
  - rnd = (sum + (1 << (FRAC-1))) >>> FRAC, which rounds half toward +inf.
  - sat = clamp(rnd, -128, 127)
  - m_data = (RELU_EN && sat < 0) ? 0 : sat
- m_ch and m_last_ch are registered with the channel actually used for the beat.

Test Plan:
- Reset then idle: after rst, check m_valid = 0, s_ready = 1, rom_row = 0, m_data = 0. With s_valid held low the outputs stay unchanged.
- Bias ROM loaded with ch0 = -12 and ch6 = 18, RELU_EN = 0:
  - ch0, s_data = 0 -> m_data = -12.
  - ch6, s_data = 12800 -> m_data = 118.
  - m_last_ch = 1 only on ch15; the next beat's m_ch = 0 (wrap).
- Rounding on ch5 (bias 0):
  - s_data = 64 -> 1
  - s_data = 63 -> 0
  - s_data = -64 -> 0
  - s_data = -65 -> -1
- Saturation and ReLU:
  - s_data = 25600 -> 127.
  - s_data = -38400 -> -128 with RELU_EN = 0, 0 with RELU_EN = 1.
- Backpressure: m_ready low for 3 cycles with s_valid held high.
  - Expect s_ready = 0 and m_data/m_ch stable.
  - Expect ch_cnt unchanged and no beat lost or duplicated across 16 beats.
- ch_clr at ch_cnt = 9, asserted together with an accept -> that beat has m_ch = 0 and the next beat has m_ch = 1. rst asserted while m_valid && !m_ready -> m_valid = 0 next cycle.

Source files
------------

// File: rtl/conv_bias_apply_stream.sv
// Streaming bias-add / requantise stage: Q.14 accumulator + Q1.7 bias from a
// zero-latency ROM, rounded, saturated to Q1.7, optional ReLU, one output register.
module conv_bias_apply_stream #(
    parameter int NUM_CH  = 16,
    parameter int ACC_W   = 24,
    parameter int FRAC    = 7,
    parameter int RELU_EN = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ch_clr,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [ACC_W-1:0] s_data,
    output logic [15:0]      rom_row,
    output logic [15:0]      rom_col,
    input  logic [7:0]       rom_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [7:0]       m_data,
    output logic [15:0]      m_ch,
    output logic             m_last_ch
);

    localparam int W = ACC_W + 2;
    localparam logic [15:0]         LAST_CH = 16'(NUM_CH - 1);
    localparam logic signed [W-1:0] HALF    = W'(1) << (FRAC - 1);
    localparam logic signed [W-1:0] SAT_MAX = W'(127);
    localparam logic signed [W-1:0] SAT_MIN = -W'(128);

    logic [15:0]         ch_cnt;
    logic [15:0]         ch_used;
    logic [15:0]         ch_next;
    logic                accept;
    logic signed [W-1:0] acc_ext;
    logic signed [W-1:0] bias_ext;
    logic signed [W-1:0] sum;
    logic signed [W-1:0] rnd;
    logic [7:0]          sat;
    logic [7:0]          result;

    // A clear in the same cycle as a beat redirects that beat to channel 0.
    assign ch_used = ch_clr ? '0 : ch_cnt;
    assign ch_next = (ch_used == LAST_CH) ? '0 : ch_used + 16'd1;
    assign rom_row = ch_used;
    assign rom_col = '0;

    assign s_ready = !m_valid || m_ready;
    assign accept  = s_valid && s_ready;

    always_comb begin
        acc_ext  = {{2{s_data[ACC_W-1]}}, s_data};
        bias_ext = {{(W-8){rom_data[7]}}, rom_data};
        sum      = acc_ext + (bias_ext <<< FRAC);
        // Arithmetic shift after adding half rounds ties toward +inf.
        rnd      = (sum + HALF) >>> FRAC;
        if (rnd > SAT_MAX) begin
            sat = 8'sd127;
        end else if (rnd < SAT_MIN) begin
            sat = 8'h80;
        end else begin
            sat = rnd[7:0];
        end
        if ((RELU_EN != 0) && sat[7]) begin
            result = '0;
        end else begin
            result = sat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ch_cnt    <= '0;
            m_valid   <= 1'b0;
            m_data    <= '0;
            m_ch      <= '0;
            m_last_ch <= 1'b0;
        end else if (accept) begin
            m_valid   <= 1'b1;
            m_data    <= result;
            m_ch      <= ch_used;
            m_last_ch <= (ch_used == LAST_CH);
            ch_cnt    <= ch_next;
        end else begin
            if (m_ready) begin
                m_valid <= 1'b0;
            end
            if (ch_clr) begin
                ch_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_conv_bias_apply_stream.sv
// Randomised + directed bench for conv_bias_apply_stream, two instances
// (ReLU off / on) sharing stimulus, checked against an integer reference model.
module tb_conv_bias_apply_stream;

    localparam int NUM_CH = 16;
    localparam int ACC_W  = 24;

    logic             clk = 1'b0;
    logic             rst;
    logic             ch_clr;
    logic             s_valid;
    logic [ACC_W-1:0] s_data;
    logic             m_ready;

    logic        s_ready0, s_ready1;
    logic [15:0] rom_row0, rom_row1, rom_col0, rom_col1;
    logic [7:0]  rom_data0, rom_data1;
    logic        m_valid0, m_valid1;
    logic [7:0]  m_data0, m_data1;
    logic [15:0] m_ch0, m_ch1;
    logic        m_last0, m_last1;

    logic signed [7:0] bias_rom [NUM_CH];

    assign rom_data0 = bias_rom[rom_row0[3:0]];
    assign rom_data1 = bias_rom[rom_row1[3:0]];

    always #5 clk = ~clk;

    conv_bias_apply_stream #(.NUM_CH(NUM_CH), .ACC_W(ACC_W), .FRAC(7), .RELU_EN(0)) dut (
        .clk(clk), .rst(rst), .ch_clr(ch_clr),
        .s_valid(s_valid), .s_ready(s_ready0), .s_data(s_data),
        .rom_row(rom_row0), .rom_col(rom_col0), .rom_data(rom_data0),
        .m_valid(m_valid0), .m_ready(m_ready), .m_data(m_data0),
        .m_ch(m_ch0), .m_last_ch(m_last0)
    );

    conv_bias_apply_stream #(.NUM_CH(NUM_CH), .ACC_W(ACC_W), .FRAC(7), .RELU_EN(1)) dut_relu (
        .clk(clk), .rst(rst), .ch_clr(ch_clr),
        .s_valid(s_valid), .s_ready(s_ready1), .s_data(s_data),
        .rom_row(rom_row1), .rom_col(rom_col1), .rom_data(rom_data1),
        .m_valid(m_valid1), .m_ready(m_ready), .m_data(m_data1),
        .m_ch(m_ch1), .m_last_ch(m_last1)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // reference state
    bit mv;
    int cnt;
    int e_data, e_relu, e_ch;
    bit e_last;
    int n_in, n_out;

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Round-half-up of (s + b*2^7) / 2^7, clamp to int8, optional ReLU.
    function automatic int ref_q(input int s, input int b, input bit relu);
        int q, r;
        q = s + b * 128 + 64;
        r = (q >= 0) ? q / 128 : -((-q + 127) / 128);
        if (r > 127)  r = 127;
        if (r < -128) r = -128;
        if (relu && r < 0) r = 0;
        return r;
    endfunction

    task automatic step(input bit sv, input int sd, input bit mr, input bit clr, input bit r);
        bit acc;
        int used;
        s_valid = sv;
        s_data  = sd[ACC_W-1:0];
        m_ready = mr;
        ch_clr  = clr;
        rst     = r;
        @(negedge clk);
        used = clr ? 0 : cnt;
        check("s_ready", int'(s_ready0), int'(!mv || mr));
        check("s_ready_relu", int'(s_ready1), int'(!mv || mr));
        check("rom_row", int'(rom_row0), used);
        check("rom_col", int'(rom_col0), 0);
        acc = sv && (!mv || mr);
        if (!r && mv && mr) n_out++;
        @(posedge clk);
        #1;
        if (r) begin
            mv = 0; cnt = 0; e_data = 0; e_relu = 0; e_ch = 0; e_last = 0;
        end else if (acc) begin
            e_data = ref_q(sd, int'(bias_rom[used]), 1'b0);
            e_relu = ref_q(sd, int'(bias_rom[used]), 1'b1);
            e_ch   = used;
            e_last = (used == NUM_CH - 1);
            mv     = 1;
            cnt    = (used + 1) % NUM_CH;
            n_in++;
        end else begin
            if (mv && mr) mv = 0;
            if (clr) cnt = 0;
        end
        check("m_valid", int'(m_valid0), int'(mv));
        check("m_valid_relu", int'(m_valid1), int'(mv));
        check("m_data", int'($signed(m_data0)), e_data);
        check("m_data_relu", int'($signed(m_data1)), e_relu);
        check("m_ch", int'(m_ch0), e_ch);
        check("m_last_ch", int'(m_last0), int'(e_last));
    endtask

    // Clear the counter (no beat) then advance to channel ch with filler beats.
    task automatic goto_ch(input int ch);
        step(0, 0, 1, 1, 0);
        for (int i = 0; i < ch; i++) step(1, int'($urandom_range(0, 4000)) - 2000, 1, 0, 0);
    endtask

    task automatic beat_expect(input string tag, input int ch, input int sd,
                               input int exp0, input int exp1);
        goto_ch(ch);
        step(1, sd, 1, 0, 0);
        check({tag, "_ch"}, int'(m_ch0), ch);
        check(tag, int'($signed(m_data0)), exp0);
        check({tag, "_relu"}, int'($signed(m_data1)), exp1);
    endtask

    initial begin
        for (int i = 0; i < NUM_CH; i++) bias_rom[i] = 8'($urandom_range(0, 255));
        bias_rom[0] = -8'sd12;
        bias_rom[5] = 8'sd0;
        bias_rom[6] = 8'sd18;
        rst = 1; ch_clr = 0; s_valid = 0; s_data = '0; m_ready = 1;
        mv = 0; cnt = 0; e_data = 0; e_relu = 0; e_ch = 0; e_last = 0;
        n_in = 0; n_out = 0;
        @(posedge clk);
        #1;

        // reset then idle
        step(0, 0, 1, 0, 1);
        check("rst_m_valid", int'(m_valid0), 0);
        check("rst_m_data", int'(m_data0), 0);
        for (int i = 0; i < 4; i++) step(0, int'($urandom_range(0, 1000)), i[0], 0, 0);

        // directed arithmetic
        beat_expect("ch0_bias", 0, 0, -12, 0);
        beat_expect("ch6_bias", 6, 12800, 118, 118);
        beat_expect("rnd_p64", 5, 64, 1, 1);
        beat_expect("rnd_p63", 5, 63, 0, 0);
        beat_expect("rnd_m64", 5, -64, 0, 0);
        beat_expect("rnd_m65", 5, -65, -1, 0);
        beat_expect("sat_pos", 5, 25600, 127, 127);
        beat_expect("sat_neg", 5, -38400, -128, 0);

        // wrap: last_ch only on ch15, then back to 0
        goto_ch(0);
        for (int i = 0; i < NUM_CH + 1; i++) begin
            step(1, int'($urandom_range(0, 20000)) - 10000, 1, 0, 0);
            check("wrap_last", int'(m_last0), int'(i == NUM_CH - 1));
        end
        check("wrap_ch", int'(m_ch0), 0);

        // backpressure: 16 beats, s_valid held, m_ready low in 3-cycle stretches
        goto_ch(0);
        n_in = 0; n_out = 0;
        while (n_in < 16) begin
            step(1, int'($urandom_range(0, 60000)) - 30000, 1, 0, 0);
            for (int k = 0; k < 3; k++) begin
                step(1, int'($urandom_range(0, 60000)) - 30000, 0, 0, 0);
                check("bp_s_ready", int'(s_ready0), 0);
            end
        end
        step(0, 0, 1, 0, 0);
        check("bp_beats", n_out, n_in);

        // ch_clr coincident with an accept at ch_cnt = 9
        goto_ch(9);
        step(1, 100, 1, 1, 0);
        check("clr_acc_ch", int'(m_ch0), 0);
        step(1, 100, 1, 0, 0);
        check("clr_next_ch", int'(m_ch0), 1);

        // reset while holding a result
        step(1, 500, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        check("rst_hold_valid", int'(m_valid0), 0);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) != 0, int'($urandom_range(0, 80000)) - 40000,
                 $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 99) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
